// File: rtl/uart_xcvr.sv
// uart_xcvr: single-clock UART transceiver with baud prescaler, TX/RX FSMs and TX/RX FIFOs.
// Optional feature macro: UART_XCVR_LOOPBACK_EN adds cfg_loopback_i (internal TX -> RX loopback).

module uart_xcvr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign count   = count_reg;
    // Head is forced to zero when empty so outputs are defined straight out of reset.
    assign rdata   = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

module uart_xcvr #(
    parameter int FIFO_DEPTH = 8,
    parameter int OVS        = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                              clk_i,
    input  logic                              arst_ni,
    input  logic                              cfg_en_i,
    input  logic [DIV_WIDTH-1:0]              cfg_div_i,
    input  logic [1:0]                        cfg_data_bits_i,
    input  logic                              cfg_parity_en_i,
    input  logic                              cfg_parity_type_i,
    input  logic                              cfg_stop_bits_i,
    input  logic                              cfg_rx_int_en_i,
`ifdef UART_XCVR_LOOPBACK_EN
    input  logic                              cfg_loopback_i,
`endif
    input  logic                              tx_flush_i,
    input  logic                              rx_flush_i,
    input  logic [7:0]                        tx_data_i,
    input  logic                              tx_valid_i,
    output logic                              tx_ready_o,
    output logic [7:0]                        rx_data_o,
    output logic                              rx_perr_o,
    output logic                              rx_ferr_o,
    output logic                              rx_valid_o,
    input  logic                              rx_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_count_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count_o,
    output logic                              overrun_o,
    input  logic                              overrun_clr_i,
    output logic                              irq_o,
    output logic                              tx_o,
    input  logic                              rx_i
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(OVS);
    localparam logic [OW-1:0] OVS_LAST  = OW'(OVS - 1);
    localparam logic [OW-1:0] HALF_LAST = OW'(OVS / 2 - 1);

    localparam logic [2:0] TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
                           TX_PARITY = 3'd3, TX_STOP1 = 3'd4, TX_STOP2 = 3'd5;
    localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2,
                           RX_PARITY = 3'd3, RX_STOP = 3'd4;

    // Prescaler
    logic [DIV_WIDTH-1:0] pre_cnt_reg;
    logic [DIV_WIDTH-1:0] div_last;
    logic                 tick;
    logic                 alive_reg;

    assign div_last = (cfg_div_i == '0) ? '0 : cfg_div_i - DIV_WIDTH'(1);
    assign tick     = cfg_en_i && (pre_cnt_reg >= div_last);

    always_ff @(posedge clk_i) begin
        if (!arst_ni || !cfg_en_i) pre_cnt_reg <= '0;
        else if (tick)             pre_cnt_reg <= '0;
        else                       pre_cnt_reg <= pre_cnt_reg + DIV_WIDTH'(1);
    end

    // Holds tx_ready_o low until the first edge after reset release.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) alive_reg <= 1'b0;
        else          alive_reg <= 1'b1;
    end

    // TX FIFO and frame setup
    logic [7:0]    tx_head;
    logic [7:0]    tx_mask;
    logic [7:0]    tx_bits;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_pop;
    logic [2:0]    tx_state_reg;
    logic [OW-1:0] tx_ovs_reg;
    logic [2:0]    tx_idx_reg;
    logic [2:0]    tx_last_reg;
    logic [7:0]    tx_shift_reg;
    logic          tx_par_en_reg;
    logic          tx_par_reg;
    logic          tx_stop2_reg;
    logic          tx_line_reg;

    assign tx_ready_o = alive_reg && !tx_full && !tx_flush_i;
    assign tx_pop     = (tx_state_reg == TX_IDLE) && cfg_en_i && !tx_empty && !tx_flush_i;

    uart_xcvr_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CW(CW)) u_tx_fifo (
        .clk(clk_i), .rst_n(arst_ni), .flush(tx_flush_i),
        .push(tx_valid_i && tx_ready_o), .wdata(tx_data_i),
        .pop(tx_pop), .rdata(tx_head), .count(tx_count_o),
        .full(tx_full), .empty(tx_empty)
    );

    for (genvar gi = 0; gi < 8; gi++) begin : g_tx_mask
        assign tx_mask[gi] = (4'(gi) < ({2'b00, cfg_data_bits_i} + 4'd5));
    end
    assign tx_bits = tx_head & tx_mask;

    always_ff @(posedge clk_i) begin
        if (!arst_ni || !cfg_en_i) begin
            tx_state_reg  <= TX_IDLE;
            tx_ovs_reg    <= '0;
            tx_idx_reg    <= '0;
            tx_last_reg   <= '0;
            tx_shift_reg  <= '0;
            tx_par_en_reg <= 1'b0;
            tx_par_reg    <= 1'b0;
            tx_stop2_reg  <= 1'b0;
            tx_line_reg   <= 1'b1;
        end else if (tx_state_reg == TX_IDLE) begin
            if (tx_pop) begin
                tx_state_reg  <= TX_START;
                tx_ovs_reg    <= '0;
                tx_idx_reg    <= '0;
                tx_last_reg   <= 3'(cfg_data_bits_i) + 3'd4;
                tx_shift_reg  <= tx_bits;
                tx_par_en_reg <= cfg_parity_en_i;
                tx_par_reg    <= (^tx_bits) ^ cfg_parity_type_i;
                tx_stop2_reg  <= cfg_stop_bits_i;
                tx_line_reg   <= 1'b0;
            end
        end else if (tick) begin
            if (tx_ovs_reg != OVS_LAST) begin
                tx_ovs_reg <= tx_ovs_reg + OW'(1);
            end else begin
                tx_ovs_reg <= '0;
                case (tx_state_reg)
                    TX_START: begin
                        tx_state_reg <= TX_DATA;
                        tx_line_reg  <= tx_shift_reg[0];
                    end
                    TX_DATA: begin
                        if (tx_idx_reg == tx_last_reg) begin
                            tx_state_reg <= tx_par_en_reg ? TX_PARITY : TX_STOP1;
                            tx_line_reg  <= tx_par_en_reg ? tx_par_reg : 1'b1;
                        end else begin
                            tx_idx_reg   <= tx_idx_reg + 3'd1;
                            tx_shift_reg <= tx_shift_reg >> 1;
                            tx_line_reg  <= tx_shift_reg[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state_reg <= TX_STOP1;
                        tx_line_reg  <= 1'b1;
                    end
                    TX_STOP1: tx_state_reg <= tx_stop2_reg ? TX_STOP2 : TX_IDLE;
                    default:  tx_state_reg <= TX_IDLE;
                endcase
            end
        end
    end

    // Serial routing
    logic rx_src;
`ifdef UART_XCVR_LOOPBACK_EN
    assign tx_o   = cfg_loopback_i ? 1'b1 : tx_line_reg;
    assign rx_src = cfg_loopback_i ? tx_line_reg : rx_i;
`else
    assign tx_o   = tx_line_reg;
    assign rx_src = rx_i;
`endif

    // RX synchroniser, deserialiser and FIFO
    logic [1:0]    sync_reg;
    logic          rx_s;
    logic          rx_prev_reg;
    logic [2:0]    rx_state_reg;
    logic [OW-1:0] rx_ovs_reg;
    logic [2:0]    rx_idx_reg;
    logic [2:0]    rx_last_reg;
    logic          rx_par_en_reg;
    logic          rx_par_type_reg;
    logic          rx_par_acc_reg;
    logic          rx_perr_reg;
    logic [7:0]    rx_data_reg;
    logic          rx_push_reg;
    logic [9:0]    rx_entry_reg;
    logic [9:0]    rx_head;
    logic          rx_full;
    logic          rx_empty;
    logic          overrun_reg;
    logic          irq_reg;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            sync_reg    <= 2'b11;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[0], rx_src};
            rx_prev_reg <= rx_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni || !cfg_en_i) begin
            rx_state_reg    <= RX_IDLE;
            rx_ovs_reg      <= '0;
            rx_idx_reg      <= '0;
            rx_last_reg     <= '0;
            rx_par_en_reg   <= 1'b0;
            rx_par_type_reg <= 1'b0;
            rx_par_acc_reg  <= 1'b0;
            rx_perr_reg     <= 1'b0;
            rx_data_reg     <= '0;
            rx_push_reg     <= 1'b0;
            rx_entry_reg    <= '0;
        end else begin
            rx_push_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_prev_reg && !rx_s) begin
                        rx_state_reg    <= RX_START;
                        rx_ovs_reg      <= '0;
                        rx_idx_reg      <= '0;
                        rx_last_reg     <= 3'(cfg_data_bits_i) + 3'd4;
                        rx_par_en_reg   <= cfg_parity_en_i;
                        rx_par_type_reg <= cfg_parity_type_i;
                        rx_par_acc_reg  <= 1'b0;
                        rx_perr_reg     <= 1'b0;
                        rx_data_reg     <= '0;
                    end
                end
                RX_START: begin
                    // Half a bit in, a line back at 1 means a glitch, not a start bit.
                    if (tick) begin
                        if (rx_ovs_reg != HALF_LAST) begin
                            rx_ovs_reg <= rx_ovs_reg + OW'(1);
                        end else begin
                            rx_ovs_reg   <= '0;
                            rx_state_reg <= rx_s ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (rx_ovs_reg != OVS_LAST) begin
                            rx_ovs_reg <= rx_ovs_reg + OW'(1);
                        end else begin
                            rx_ovs_reg <= '0;
                            case (rx_state_reg)
                                RX_DATA: begin
                                    rx_data_reg[rx_idx_reg] <= rx_s;
                                    rx_par_acc_reg <= rx_par_acc_reg ^ rx_s;
                                    if (rx_idx_reg == rx_last_reg)
                                        rx_state_reg <= rx_par_en_reg ? RX_PARITY : RX_STOP;
                                    else
                                        rx_idx_reg <= rx_idx_reg + 3'd1;
                                end
                                RX_PARITY: begin
                                    rx_perr_reg  <= rx_s ^ rx_par_acc_reg ^ rx_par_type_reg;
                                    rx_state_reg <= RX_STOP;
                                end
                                default: begin
                                    rx_push_reg  <= 1'b1;
                                    rx_entry_reg <= {rx_perr_reg, !rx_s, rx_data_reg};
                                    rx_state_reg <= RX_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    uart_xcvr_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH), .CW(CW)) u_rx_fifo (
        .clk(clk_i), .rst_n(arst_ni), .flush(rx_flush_i),
        .push(rx_push_reg), .wdata(rx_entry_reg),
        .pop(rx_ready_i), .rdata(rx_head), .count(rx_count_o),
        .full(rx_full), .empty(rx_empty)
    );

    assign rx_valid_o = !rx_empty;
    assign rx_perr_o  = rx_head[9];
    assign rx_ferr_o  = rx_head[8];
    assign rx_data_o  = rx_head[7:0];

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            overrun_reg <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            overrun_reg <= (rx_push_reg && rx_full && !rx_flush_i) || (overrun_reg && !overrun_clr_i);
            irq_reg     <= cfg_rx_int_en_i && (rx_valid_o || overrun_reg);
        end
    end

    assign overrun_o = overrun_reg;
    assign irq_o     = irq_reg;
endmodule

// File: tb/tb_uart_xcvr.sv
// Directed self-checking bench for uart_xcvr: expected RX entries are queued when frames are driven.
module tb_uart_xcvr;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          arst_ni;
    logic          cfg_en;
    logic [15:0]   cfg_div;
    logic [1:0]    cfg_bits;
    logic          par_en, par_type, stop2, int_en;
    logic          tx_flush, rx_flush;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_ready;
    logic [7:0]    rx_data;
    logic          rx_perr, rx_ferr, rx_valid, rx_ready;
    logic [CW-1:0] tx_count, rx_count;
    logic          overrun, overrun_clr, irq;
    logic          tx_line, rx_line, rx_drv, ext_loop;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    assign rx_line = ext_loop ? tx_line : rx_drv;
    always #5 clk = ~clk;

    uart_xcvr #(.FIFO_DEPTH(DEPTH), .OVS(16), .DIV_WIDTH(16)) dut (
        .clk_i(clk), .arst_ni(arst_ni), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .cfg_data_bits_i(cfg_bits), .cfg_parity_en_i(par_en), .cfg_parity_type_i(par_type),
        .cfg_stop_bits_i(stop2), .cfg_rx_int_en_i(int_en),
`ifdef UART_XCVR_LOOPBACK_EN
        .cfg_loopback_i(1'b0),
`endif
        .tx_flush_i(tx_flush), .rx_flush_i(rx_flush),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_perr_o(rx_perr), .rx_ferr_o(rx_ferr),
        .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .tx_count_o(tx_count), .rx_count_o(rx_count),
        .overrun_o(overrun), .overrun_clr_i(overrun_clr), .irq_o(irq),
        .tx_o(tx_line), .rx_i(rx_line)
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tx_push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cycles(1);
        tx_valid = 1'b0;
        $display("tx push data=%02h", d);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_ok, input logic par_flip,
                           input logic expect_push);
        int bitc;
        int nbits;
        logic [7:0] m;
        bitc  = 16 * int'(cfg_div);
        nbits = int'(cfg_bits) + 5;
        m     = d & 8'((1 << nbits) - 1);
        if (expect_push) exp_q.push_back({par_en & par_flip, ~stop_ok, m});
        $display("rx send data=%02h stop_ok=%0d par_flip=%0d", m, stop_ok, par_flip);
        rx_drv = 1'b0;
        cycles(bitc);
        for (int i = 0; i < nbits; i++) begin
            rx_drv = m[i];
            cycles(bitc);
        end
        if (par_en) begin
            rx_drv = (^m) ^ par_type ^ par_flip;
            cycles(bitc);
        end
        rx_drv = stop_ok;
        cycles(bitc);
        rx_drv = 1'b1;
        cycles(bitc);
    endtask

    task automatic pop_check(input string tag);
        int w;
        logic [9:0] e;
        w = 0;
        while (!rx_valid && w < 2000) begin
            cycles(1);
            w++;
        end
        check({tag, "_valid"}, rx_valid, 1);
        if (rx_valid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
            check(tag, {rx_perr, rx_ferr, rx_data}, e);
            $display("rx pop %s data=%02h perr=%0d ferr=%0d", tag, rx_data, rx_perr, rx_ferr);
            rx_ready = 1'b1;
            cycles(1);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        arst_ni = 1'b0; cfg_en = 1'b0; cfg_div = 16'd1; cfg_bits = 2'd3;
        par_en = 1'b0; par_type = 1'b0; stop2 = 1'b0; int_en = 1'b0;
        tx_flush = 1'b0; rx_flush = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        rx_ready = 1'b0; overrun_clr = 1'b0; rx_drv = 1'b1; ext_loop = 1'b0;
        cycles(3);
        check("rst_tx_o", tx_line, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_entry", {rx_perr, rx_ferr, rx_data}, 0);
        check("rst_counts", {tx_count, rx_count}, 0);
        check("rst_overrun_irq", {overrun, irq}, 0);
        arst_ni = 1'b1;
        cycles(1);
        check("ready_after_reset", tx_ready, 1);

        // 8N1 0x55 at div=1: 16 cycles per bit, 160-cycle frame
        cfg_en = 1'b1;
        cycles(2);
        tx_push(8'h55);
        check("tx_count_push", tx_count, 1);
        check("tx_idle_before_pop", tx_line, 1);
        cycles(1);
        check("tx_count_pop", tx_count, 0);
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 160; k++) begin
            if ((k % 8) == 0 || (k % 16) == 15) check($sformatf("tx_bit_k%0d", k), tx_line, frame[k / 16]);
            cycles(1);
        end
        check("tx_idle_after_frame", tx_line, 1);

        // RX framing error then recovery, parity good/bad
        send_rx(8'hA5, 1'b0, 1'b0, 1'b1);
        pop_check("rx_ferr");
        send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
        pop_check("rx_good");
        par_en = 1'b1;
        send_rx(8'h07, 1'b1, 1'b0, 1'b1);
        pop_check("rx_par_ok");
        send_rx(8'h07, 1'b1, 1'b1, 1'b1);
        pop_check("rx_par_bad");
        par_en = 1'b0;

        // False start: 4 ticks low then high
        rx_drv = 1'b0;
        cycles(4);
        rx_drv = 1'b1;
        cycles(40);
        check("false_start_count", rx_count, 0);
        check("false_start_valid", rx_valid, 0);
        send_rx(8'h81, 1'b1, 1'b0, 1'b1);
        pop_check("after_false_start");

        // External loopback, div=3, 7O2, 0xC3 -> 0x43
        cfg_div = 16'd3; cfg_bits = 2'd2; par_en = 1'b1; par_type = 1'b1; stop2 = 1'b1;
        ext_loop = 1'b1;
        cycles(5);
        exp_q.push_back({2'b00, 8'h43});
        tx_push(8'hC3);
        pop_check("loop_7o2");
        cycles(150);
        ext_loop = 1'b0; cfg_div = 16'd1; cfg_bits = 2'd3; par_en = 1'b0; par_type = 1'b0; stop2 = 1'b0;
        cycles(5);

        // Overrun: 9 frames into an 8-deep FIFO
        int_en = 1'b1;
        for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i), 1'b1, 1'b0, i < 8);
        cycles(4);
        check("ovr_count", rx_count, 8);
        check("ovr_flag", overrun, 1);
        check("ovr_irq", irq, 1);
        overrun_clr = 1'b1;
        cycles(1);
        overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        for (int i = 0; i < 8; i++) pop_check($sformatf("ovr_pop%0d", i));
        check("ovr_drained", rx_count, 0);
        cycles(1);
        check("irq_low_after_drain", irq, 0);

        // TX flush with frame in flight and 3 queued; the byte pushed during flush is dropped
        ext_loop = 1'b1;
        cycles(2);
        exp_q.push_back({2'b00, 8'hA1});
        tx_valid = 1'b1;
        tx_data = 8'hA1; cycles(1);
        tx_data = 8'hB2; cycles(1);
        tx_data = 8'hC3; cycles(1);
        tx_data = 8'hD4; cycles(1);
        check("flush_pre_count", tx_count, 3);
        tx_flush = 1'b1;
        tx_data  = 8'hE5;
        #1;
        check("flush_ready_low", tx_ready, 0);
        cycles(1);
        tx_flush = 1'b0;
        tx_valid = 1'b0;
        check("flush_count", tx_count, 0);
        pop_check("flush_inflight");
        cycles(300);
        check("flush_nothing_more", rx_count, 0);
        check("flush_tx_empty", tx_count, 0);
        ext_loop = 1'b0;

        // Disable aborts a frame mid-bit
        tx_push(8'h00);
        cycles(20);
        check("dis_mid_frame_low", tx_line, 0);
        cfg_en = 1'b0;
        cycles(1);
        check("dis_tx_high", tx_line, 1);
        check("dis_scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
